tile_renderer: RTL and testbench



---
 rtl/tile_renderer_if.sv | 42 ++++
 rtl/tile_renderer.sv | 207 ++++++++++++++++++++
 tb/tb_tile_renderer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_renderer_if.sv
// tile_renderer_if
// Bundles everything the tile renderer exchanges with the outside world,
// apart from clk and rst:
//   - video timing inputs: line_start, active, pix_y
//   - three read ports (tile pattern, attribute/map, palette), each with a
//     registered address and a data bus. The memory returns data in the
//     cycle after the address register changes.
//   - the pixel output stage: pixel_color, pixel_valid, fetch_underrun
// Modports:
//   master - the renderer. It issues the memory addresses and drives the
//            pixel outputs.
//   slave  - the environment: timing generator, memories and DAC side.
interface tile_renderer_if;
  logic        line_start;
  logic        active;
  logic [9:0]  pix_y;

  logic [10:0] tile_memory_read_addr;
  logic [7:0]  tile_memory_read_data;
  logic [11:0] attribute_memory_read_addr;
  logic [7:0]  attribute_memory_read_data;
  logic [3:0]  color_memory_read_addr;
  logic [7:0]  color_memory_read_data;

  logic [7:0]  pixel_color;
  logic        pixel_valid;
  logic        fetch_underrun;

  modport master (
    input  line_start, active, pix_y,
    input  tile_memory_read_data, attribute_memory_read_data, color_memory_read_data,
    output tile_memory_read_addr, attribute_memory_read_addr, color_memory_read_addr,
    output pixel_color, pixel_valid, fetch_underrun
  );

  modport slave (
    output line_start, active, pix_y,
    output tile_memory_read_data, attribute_memory_read_data, color_memory_read_data,
    input  tile_memory_read_addr, attribute_memory_read_addr, color_memory_read_addr,
    input  pixel_color, pixel_valid, fetch_underrun
  );
endinterface

// File: rtl/tile_renderer.sv
// tile_renderer
// Renders one scanline of a COLS x ROWS tile display. The fetch FSM runs
// ahead of the beam and fills a one-tile "next" buffer with the tile's
// pattern byte and attribute byte. The shifter loads that buffer once per
// tile period. The colour stage resolves each pixel through the palette.
// Ports:
//   clk - pixel clock (one pixel per cycle)
//   rst - synchronous, active-high reset
//   bus - tile_renderer_if.master: timing in, memory read ports, pixel out
// Output latency from an active cycle to its pixel_color/pixel_valid is two
// clocks.
module tile_renderer #(
  parameter int          COLS        = 40,
  parameter int          ROWS        = 30,
  parameter int          SCALE_SHIFT = 1,
  parameter logic [11:0] MAP_BASE    = 12'h000,
  parameter logic [11:0] ATTR_BASE   = 12'h800
) (
  input logic            clk,
  input logic            rst,
  tile_renderer_if.master bus
);
  localparam int               COL_W    = $clog2(COLS + 1);
  localparam int               CNT_W    = 3 + SCALE_SHIFT;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] NUM_COLS = COL_W'(COLS);
  localparam logic [9:0]       NUM_ROWS = 10'(ROWS);

  typedef enum logic [2:0] {IDLE, MAP, ATTR, PATTERN, LATCH, WAIT} state_t;

  state_t           state;
  logic [11:0]      row_base;
  logic [2:0]       line_in_tile;
  logic [COL_W-1:0] col;
  logic [7:0]       tile_index;
  logic [7:0]       attr_byte;
  logic [7:0]       next_pattern;
  logic [7:0]       next_attr;
  logic             next_full;
  logic [7:0]       cur_pattern;
  logic [7:0]       cur_attr;
  logic             cur_ok;
  logic [CNT_W-1:0] pix_cnt;
  logic [COL_W-1:0] consumed;
  logic             line_blank;
  logic             active_d1;

  logic [11:0]      attr_addr;
  logic [10:0]      tile_addr;
  logic [3:0]       color_addr;
  logic [7:0]       pixel_color;
  logic             pixel_valid;
  logic             fetch_underrun;

  logic [9:0]       row_calc;
  logic             load;
  logic             tiles_left;
  logic [7:0]       src_pattern;
  logic [7:0]       src_attr;
  logic             src_ok;
  logic [2:0]       bit_sel;
  logic             pix_bit;
  logic [3:0]       pix_index;

  assign row_calc = bus.pix_y >> (3 + SCALE_SHIFT);

  assign bus.attribute_memory_read_addr = attr_addr;
  assign bus.tile_memory_read_addr      = tile_addr;
  assign bus.color_memory_read_addr     = color_addr;
  assign bus.pixel_color                = pixel_color;
  assign bus.pixel_valid                = pixel_valid;
  assign bus.fetch_underrun             = fetch_underrun;

  // Pixel selection for the current active cycle. On a load cycle the pixel
  // comes straight from the next buffer, so the first pixel of every tile
  // is on time. A tile that was not fetched in time, or that lies beyond
  // the last column, is shown as palette index 0.
  always_comb begin
    load        = bus.active && !bus.line_start && (pix_cnt == '0);
    tiles_left  = (consumed != NUM_COLS);
    src_pattern = cur_pattern;
    src_attr    = cur_attr;
    src_ok      = cur_ok;
    if (load) begin
      src_pattern = next_pattern;
      src_attr    = next_attr;
      src_ok      = next_full && tiles_left && !line_blank;
    end
    bit_sel   = pix_cnt[SCALE_SHIFT +: 3];
    pix_bit   = src_pattern[3'd7 - bit_sel];
    pix_index = 4'd0;
    if (src_ok && !bus.line_start) begin
      pix_index = pix_bit ? src_attr[7:4] : src_attr[3:0];
    end
  end

  // Fetch FSM, shifter and colour stage share one register block because
  // next_full is set by the fetch side and cleared by the shifter. The
  // FSM's set is written last, so it wins on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      row_base       <= '0;
      line_in_tile   <= '0;
      col            <= '0;
      tile_index     <= '0;
      attr_byte      <= '0;
      next_pattern   <= '0;
      next_attr      <= '0;
      next_full      <= 1'b0;
      cur_pattern    <= '0;
      cur_attr       <= '0;
      cur_ok         <= 1'b0;
      pix_cnt        <= '0;
      consumed       <= '0;
      line_blank     <= 1'b1;
      active_d1      <= 1'b0;
      attr_addr      <= '0;
      tile_addr      <= '0;
      color_addr     <= '0;
      pixel_color    <= '0;
      pixel_valid    <= 1'b0;
      fetch_underrun <= 1'b0;
    end else begin
      active_d1   <= bus.active;
      pixel_valid <= active_d1;
      color_addr  <= bus.active ? pix_index : 4'd0;
      pixel_color <= active_d1 ? bus.color_memory_read_data : 8'd0;

      if (bus.line_start) begin
        fetch_underrun <= 1'b0;
        pix_cnt        <= '0;
        consumed       <= '0;
        cur_ok         <= 1'b0;
        next_full      <= 1'b0;
        col            <= '0;
        line_in_tile   <= 3'(bus.pix_y >> SCALE_SHIFT);
        row_base       <= 12'(row_calc * COLS);
        // Rows below the tile map are blank. Addresses are held, so no
        // reads are issued for such a line.
        if (row_calc >= NUM_ROWS) begin
          state      <= IDLE;
          line_blank <= 1'b1;
        end else begin
          state      <= MAP;
          line_blank <= 1'b0;
          attr_addr  <= MAP_BASE + 12'(row_calc * COLS);
        end
      end else begin
        if (bus.active) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (load) begin
          cur_pattern <= next_pattern;
          cur_attr    <= next_attr;
          cur_ok      <= src_ok;
          next_full   <= 1'b0;
          if (tiles_left) begin
            consumed <= consumed + 1'b1;
          end
          if (!next_full && tiles_left && !line_blank) begin
            fetch_underrun <= 1'b1;
          end
        end

        // The memories answer on the registered address in the following
        // cycle. Each state therefore consumes the data for the address
        // set on entry and sets up the address for the next state.
        case (state)
          IDLE: begin
          end
          MAP: begin
            tile_index <= bus.attribute_memory_read_data;
            attr_addr  <= ATTR_BASE + row_base + 12'(col);
            state      <= ATTR;
          end
          ATTR: begin
            attr_byte <= bus.attribute_memory_read_data;
            tile_addr <= {tile_index, line_in_tile};
            state     <= PATTERN;
          end
          PATTERN: begin
            state <= LATCH;
          end
          LATCH: begin
            next_pattern <= bus.tile_memory_read_data;
            next_attr    <= attr_byte;
            next_full    <= 1'b1;
            state        <= WAIT;
          end
          WAIT: begin
            if (!next_full) begin
              if (col == LAST_COL) begin
                state <= IDLE;
              end else begin
                col       <= col + 1'b1;
                attr_addr <= MAP_BASE + row_base + 12'(col + 1'b1);
                state     <= MAP;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer
// Self-checking bench for tile_renderer with default parameters. It models
// the tile, attribute and palette memories as arrays that answer
// combinationally on the DUT's registered addresses. A negedge monitor
// records emitted pixels and every change of the attribute and tile
// addresses.
module tb_tile_renderer;
  logic clk;
  logic rst;

  tile_renderer_if bus ();

  tile_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tile_mem [0:2047];
  logic [7:0] attr_mem [0:4095];
  logic [7:0] pal      [0:15];

  assign bus.tile_memory_read_data      = tile_mem[bus.tile_memory_read_addr];
  assign bus.attribute_memory_read_data = attr_mem[bus.attribute_memory_read_addr];
  assign bus.color_memory_read_data     = pal[bus.color_memory_read_addr];

  int checks;
  int errors;

  logic [7:0]  pix_q  [$];
  logic [11:0] attr_q [$];
  logic [10:0] tile_q [$];
  logic [11:0] last_attr;
  logic [10:0] last_tile;

  // Records each valid pixel and each change of the attribute and tile
  // addresses.
  always @(negedge clk) begin
    if (bus.pixel_valid) pix_q.push_back(bus.pixel_color);
    if (bus.attribute_memory_read_addr != last_attr) attr_q.push_back(bus.attribute_memory_read_addr);
    if (bus.tile_memory_read_addr != last_tile) tile_q.push_back(bus.tile_memory_read_addr);
    last_attr = bus.attribute_memory_read_addr;
    last_tile = bus.tile_memory_read_addr;
  end

  typedef struct {
    logic [9:0]  pix_y;
    int          lead;
    int          act_len;
    bit          exp_reads;
    logic [11:0] exp_map0;
    logic [11:0] exp_attr0;
    logic [2:0]  exp_lit;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    logic        exp_underrun;
  } vec_t;

  vec_t vecs [4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses line_start. The next "@(posedge clk); #1" after this task lands
  // in the cycle that is 'lead' cycles after the line_start cycle.
  task automatic startLine(input logic [9:0] y, input int lead);
    @(posedge clk); #1;
    pix_q.delete();
    attr_q.delete();
    tile_q.delete();
    bus.line_start = 1'b1;
    bus.pix_y      = y;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    repeat (lead - 2) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [9:0] y, input int lead, input int act_len);
    startLine(y, lead);
    for (int i = 0; i < act_len + 4; i++) begin
      @(posedge clk); #1;
      bus.active = (i < act_len);
    end
    @(negedge clk);
  endtask

  logic [7:0] exp1 [16];
  logic [7:0] last_pix;
  logic [10:0] first_tile;
  int map_count;
  logic [11:0] map_max;
  int bad_main;
  int bad_tail;
  bit hold_ok;

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.line_start = 1'b0;
    bus.active     = 1'b0;
    bus.pix_y      = '0;
    last_attr      = '0;
    last_tile      = '0;

    for (int i = 0; i < 2048; i++) tile_mem[i] = 8'h00;
    for (int i = 0; i < 4096; i++) attr_mem[i] = 8'h00;
    pal = '{8'h11, 8'h03, 8'h24, 8'h36, 8'h48, 8'h5A, 8'h6C, 8'h7E,
            8'h80, 8'h92, 8'hA4, 8'hB6, 8'hC8, 8'hDA, 8'hEC, 8'hFF};
    // Row 0, column 0: tile 0x41, fg 15, bg 1, line 0 pattern 0xA5.
    attr_mem[12'h000] = 8'h41;
    attr_mem[12'h800] = 8'hF1;
    tile_mem[11'h208] = 8'hA5;
    // Row 2, column 0, line 2: pattern 0x80, fg 5, bg 10.
    attr_mem[12'h050] = 8'h07;
    attr_mem[12'h850] = 8'h5A;
    tile_mem[11'h03A] = 8'h80;
    // Row 29, column 0, line 7: pattern 0x7F, fg 2, bg 12.
    attr_mem[12'h488] = 8'hFE;
    attr_mem[12'hC88] = 8'h2C;
    tile_mem[11'h7F7] = 8'h7F;
    // Row 6: every tile uses colour 3 for both fg and bg.
    for (int c = 0; c < 40; c++) begin
      attr_mem[12'h0F0 + 12'(c)] = 8'(c);
      attr_mem[12'h8F0 + 12'(c)] = 8'h33;
    end

    exp1 = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h03,
             8'h03, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'hFF, 8'hFF};

    vecs[0] = '{pix_y: 10'd37,  lead: 20, act_len: 16, exp_reads: 1'b1, exp_map0: 12'h050,
                exp_attr0: 12'h850, exp_lit: 3'd2, exp_first: 8'h5A, exp_last: 8'hA4, exp_underrun: 1'b0};
    vecs[1] = '{pix_y: 10'd0,   lead: 3,  act_len: 16, exp_reads: 1'b1, exp_map0: 12'h000,
                exp_attr0: 12'h800, exp_lit: 3'd0, exp_first: 8'h11, exp_last: 8'h11, exp_underrun: 1'b1};
    vecs[2] = '{pix_y: 10'd480, lead: 20, act_len: 16, exp_reads: 1'b0, exp_map0: 12'h000,
                exp_attr0: 12'h000, exp_lit: 3'd0, exp_first: 8'h11, exp_last: 8'h11, exp_underrun: 1'b0};
    vecs[3] = '{pix_y: 10'd479, lead: 12, act_len: 16, exp_reads: 1'b1, exp_map0: 12'h488,
                exp_attr0: 12'hC88, exp_lit: 3'd7, exp_first: 8'hC8, exp_last: 8'h24, exp_underrun: 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_pixel_valid", 32'(bus.pixel_valid), 32'd0);
    checkOutput("reset_pixel_color", 32'(bus.pixel_color), 32'd0);
    checkOutput("reset_attr_addr", 32'(bus.attribute_memory_read_addr), 32'd0);
    checkOutput("reset_tile_addr", 32'(bus.tile_memory_read_addr), 32'd0);
    checkOutput("reset_underrun", 32'(bus.fetch_underrun), 32'd0);

    // Line 0: pixel sequence and the exact two-cycle latency.
    startLine(10'd0, 20);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.active = (i < 16);
      @(negedge clk);
      checkOutput($sformatf("line0_valid_%0d", i), 32'(bus.pixel_valid), 32'((i >= 2 && i < 18) ? 1 : 0));
      checkOutput($sformatf("line0_color_%0d", i), 32'(bus.pixel_color), 32'((i >= 2 && i < 18) ? exp1[i-2] : 8'h00));
    end
    checkOutput("line0_underrun", 32'(bus.fetch_underrun), 32'd0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].pix_y, vecs[v].lead, vecs[v].act_len);
      checkOutput($sformatf("v%0d_valid_count", v), 32'(pix_q.size()), 32'(vecs[v].act_len));
      last_pix = (pix_q.size() > 0) ? pix_q[pix_q.size()-1] : 8'hEE;
      checkOutput($sformatf("v%0d_first_pixel", v), 32'((pix_q.size() > 0) ? pix_q[0] : 8'hEE), 32'(vecs[v].exp_first));
      checkOutput($sformatf("v%0d_last_pixel", v), 32'(last_pix), 32'(vecs[v].exp_last));
      checkOutput($sformatf("v%0d_underrun", v), 32'(bus.fetch_underrun), 32'(vecs[v].exp_underrun));
      if (vecs[v].exp_reads) begin
        checkOutput($sformatf("v%0d_map_addr", v), 32'((attr_q.size() > 0) ? attr_q[0] : 12'hFFF), 32'(vecs[v].exp_map0));
        checkOutput($sformatf("v%0d_attr_addr", v), 32'((attr_q.size() > 1) ? attr_q[1] : 12'hFFF), 32'(vecs[v].exp_attr0));
        first_tile = (tile_q.size() > 0) ? tile_q[0] : 11'h7FF;
        checkOutput($sformatf("v%0d_tile_line", v), 32'(first_tile[2:0]), 32'(vecs[v].exp_lit));
      end else begin
        checkOutput($sformatf("v%0d_attr_reads", v), 32'(attr_q.size()), 32'd0);
        checkOutput($sformatf("v%0d_tile_reads", v), 32'(tile_q.size()), 32'd0);
      end
    end

    // Full line on row 6: 40 tiles of colour 3, then 8 pixels past the map.
    applyStimulus(10'd100, 20, 648);
    map_count = 0;
    map_max   = '0;
    foreach (attr_q[k]) begin
      if (attr_q[k] < 12'h800) begin
        map_count++;
        if (attr_q[k] > map_max) map_max = attr_q[k];
      end
    end
    bad_main = 0;
    bad_tail = 0;
    foreach (pix_q[k]) begin
      if (k < 640 && pix_q[k] !== 8'h36) bad_main++;
      if (k >= 640 && pix_q[k] !== 8'h11) bad_tail++;
    end
    checkOutput("full_valid_count", 32'(pix_q.size()), 32'd648);
    checkOutput("full_map_fetches", 32'(map_count), 32'd40);
    checkOutput("full_last_map_addr", 32'(map_max), 32'h117);
    checkOutput("full_bad_tile_pixels", 32'(bad_main), 32'd0);
    checkOutput("full_bad_tail_pixels", 32'(bad_tail), 32'd0);
    checkOutput("full_underrun", 32'(bus.fetch_underrun), 32'd0);

    // Reset during active pixel 100, then a clean line.
    startLine(10'd100, 20);
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk); #1;
      bus.active = 1'b1;
      rst        = (i == 100);
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.active = 1'b0;
    @(negedge clk);
    checkOutput("midrst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
    checkOutput("midrst_pixel_color", 32'(bus.pixel_color), 32'd0);
    checkOutput("midrst_attr_addr", 32'(bus.attribute_memory_read_addr), 32'd0);
    checkOutput("midrst_tile_addr", 32'(bus.tile_memory_read_addr), 32'd0);
    checkOutput("midrst_color_addr", 32'(bus.color_memory_read_addr), 32'd0);
    hold_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.attribute_memory_read_addr !== 12'h000 || bus.tile_memory_read_addr !== 11'h000) hold_ok = 1'b0;
    end
    checkOutput("midrst_addr_hold", 32'(hold_ok), 32'd1);
    applyStimulus(10'd0, 20, 16);
    checkOutput("postrst_valid_count", 32'(pix_q.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("postrst_pixel_%0d", k), 32'((pix_q.size() > k) ? pix_q[k] : 8'hEE), 32'(exp1[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
